// File: rtl/sclk_gen_pkg.sv
// Shared types and constants for the QSPI serial-clock generator.
package sclk_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_TAIL = 2'd2
  } state_t;

  // SPI modes encoded as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/sclk_gen_if.sv
// Burst request / strobe bundle between the transaction controller and sclk_gen.
interface sclk_gen_if #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 16
);
  logic [DIV_W-1:0] i_div;
  logic             i_cpol;
  logic             i_cpha;
  logic [CNT_W-1:0] i_n_cycles;
  logic             i_start;
  logic             i_stop;

  logic             o_sclk;
  logic             o_lead_edge;
  logic             o_trail_edge;
  logic             o_sample;
  logic             o_shift;
  logic             o_busy;
  logic             o_done;

  modport master (
    output i_div, i_cpol, i_cpha, i_n_cycles, i_start, i_stop,
    input  o_sclk, o_lead_edge, o_trail_edge, o_sample, o_shift, o_busy, o_done
  );

  modport slave (
    input  i_div, i_cpol, i_cpha, i_n_cycles, i_start, i_stop,
    output o_sclk, o_lead_edge, o_trail_edge, o_sample, o_shift, o_busy, o_done
  );
endinterface

// File: rtl/sclk_half_cnt.sv
// Half-period counter: counts 0..limit while enabled, flags the terminal cycle and wraps.
module sclk_half_cnt #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_limit,
  output logic             o_wrap
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_limit;

  assign o_wrap = i_en && (r_cnt == r_limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_limit <= '0;
    end else if (i_load) begin
      r_cnt   <= '0;
      r_limit <= i_limit;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_wrap ? '0 : r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/sclk_gen.sv
// Mode-configurable SCLK generator running bursts of N clocks with edge strobes.
//   state   | meaning
//   IDLE    | sclk follows cpol, waiting for start
//   RUN     | toggling sclk every div+1 cycles until 2*N edges
//   TAIL    | sclk held at idle level for div+1 cycles, then done
module sclk_gen
  import sclk_gen_pkg::*;
#(
  parameter int DIV_W = 8,
  parameter int CNT_W = 16
) (
  input logic        clk,
  input logic        rst,
  sclk_gen_if.slave  bus
);

  state_t           r_state;
  logic             r_sclk;
  logic             r_lead;
  logic             r_trail;
  logic             r_busy;
  logic             r_done;
  logic             r_cpol;
  logic             r_cpha;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W:0]   r_edges;

  logic             w_wrap;
  logic             w_load;
  logic             w_en;
  logic             w_clr;
  logic             w_last;
  logic [CNT_W:0]   w_edges_nxt;

  assign w_load      = (r_state == ST_IDLE) && bus.i_start;
  assign w_en        = (r_state != ST_IDLE);
  assign w_clr       = w_en && bus.i_stop;
  assign w_edges_nxt = r_edges + (CNT_W + 1)'(1);
  assign w_last      = (w_edges_nxt == {r_n, 1'b0});

  sclk_half_cnt #(.DIV_W(DIV_W)) u_half_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_clr   (w_clr),
    .i_en    (w_en),
    .i_limit (bus.i_div),
    .o_wrap  (w_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sclk  <= 1'b0;
      r_lead  <= 1'b0;
      r_trail <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cpol  <= 1'b0;
      r_cpha  <= 1'b0;
      r_n     <= '0;
      r_edges <= '0;
    end else begin
      r_lead  <= 1'b0;
      r_trail <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_sclk <= bus.i_cpol;
          r_busy <= 1'b0;
          if (bus.i_start) begin
            r_cpol  <= bus.i_cpol;
            r_cpha  <= bus.i_cpha;
            r_n     <= bus.i_n_cycles;
            r_edges <= '0;
            if (bus.i_n_cycles != '0) begin
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // abort beats any edge due in the same cycle
          if (bus.i_stop) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_sclk  <= r_cpol;
          end else if (w_wrap) begin
            r_sclk  <= ~r_sclk;
            r_lead  <= (r_sclk == r_cpol);
            r_trail <= (r_sclk != r_cpol);
            r_edges <= w_edges_nxt;
            if (w_last) begin
              r_state <= ST_TAIL;
            end
          end
        end
        ST_TAIL: begin
          r_sclk <= r_cpol;
          if (bus.i_stop) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_wrap) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_sclk       = r_sclk;
  assign bus.o_lead_edge  = r_lead;
  assign bus.o_trail_edge = r_trail;
  assign bus.o_sample     = r_cpha ? r_trail : r_lead;
  assign bus.o_shift      = r_cpha ? r_lead : r_trail;
  assign bus.o_busy       = r_busy;
  assign bus.o_done       = r_done;

endmodule
